// File: rtl/debug_console_pkg.sv
// Shared constants for the debug console responder: bus addresses, UART state
// encoding and status-word bit positions.
package debug_console_pkg;

   localparam logic [31:0] CON_ADDR  = 32'hF000_00D0;
   localparam logic [31:0] STAT_ADDR = 32'hF000_00D4;
   localparam logic [31:0] HALT_ADDR = 32'hE000_0000;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_BUSY      = 2;
   localparam int STAT_HALT      = 3;
   localparam int STAT_COUNT_LSB = 8;

endpackage

// File: rtl/debug_console_tx_uart.sv
// 8N1 serialiser with a valid/ready byte input; every bit lasts CLK_DIV clocks and
// a queued byte follows the stop bit directly without an idle gap.
module debug_uart_tx
   import debug_console_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clock_in,
   input  logic       reset,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx,
   output logic       busy
);

   localparam int            BW        = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   uart_state_t   state_r;
   uart_state_t   state_s;
   logic [BW-1:0] baud_r;
   logic [BW-1:0] baud_s;
   logic [2:0]    bit_r;
   logic [2:0]    bit_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_s;
   logic          tx_r;
   logic          tx_s;
   logic          baud_end_s;

   assign baud_end_s = (baud_r == BAUD_LAST);
   assign tx         = tx_r;
   assign busy       = (state_r != UART_IDLE);

   // State and datapath registers; reset parks the line high in IDLE
   always_ff @(posedge clock_in) begin
      if (!reset) begin
         state_r <= UART_IDLE;
         baud_r  <= '0;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
      end
   end

   // Next-state, bit sequencing and the pop handshake towards the FIFO
   always_comb begin
      state_s    = state_r;
      baud_s     = baud_end_s ? '0 : baud_r + BAUD_ONE;
      bit_s      = bit_r;
      shift_s    = shift_r;
      tx_s       = tx_r;
      byte_ready = 1'b0;
      case (state_r)
         UART_IDLE: begin
            baud_s     = '0;
            byte_ready = 1'b1;
            if (byte_valid) begin
               state_s = UART_START;
               shift_s = byte_data;
               tx_s    = 1'b0;
            end else begin
               tx_s = 1'b1;
            end
         end
         UART_START: begin
            if (baud_end_s) begin
               state_s = UART_DATA;
               bit_s   = 3'd0;
               tx_s    = shift_r[0];
            end else begin
               tx_s = 1'b0;
            end
         end
         UART_DATA: begin
            if (baud_end_s) begin
               if (bit_r == 3'd7) begin
                  state_s = UART_STOP;
                  tx_s    = 1'b1;
               end else begin
                  bit_s   = bit_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
                  tx_s    = shift_r[1];
               end
            end else begin
               tx_s = tx_r;
            end
         end
         UART_STOP: begin
            if (baud_end_s) begin
               byte_ready = 1'b1;
               if (byte_valid) begin
                  state_s = UART_START;
                  shift_s = byte_data;
                  tx_s    = 1'b0;
               end else begin
                  state_s = UART_IDLE;
                  tx_s    = 1'b1;
               end
            end else begin
               tx_s = 1'b1;
            end
         end
         default: begin
            state_s = UART_IDLE;
            tx_s    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/debug_console_tx.sv
// Debug console responder: captures one character per console write, inserts
// automatic line breaks, buffers into a FIFO and reports status and end-of-run.
module debug_console_tx
   import debug_console_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CLK_DIV    = 434,
   parameter int LINE_MAX   = 72
) (
   input  logic        clock_in,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] data_write,
   input  logic [3:0]  data_we,
   output logic [31:0] data_read,
   output logic        stall_sig,
   output logic        tx,
   output logic        halt_done
);

   localparam int            AW         = $clog2(FIFO_DEPTH);
   localparam int            PW         = AW + 1;
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);
   localparam logic          WRAP_EN    = (LINE_MAX > 0);
   localparam logic [7:0]    LINE_MAX_B = 8'(LINE_MAX);
   localparam logic [7:0]    LF         = 8'h0A;

   logic [7:0]    fifo_mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] count_s;
   logic [7:0]    column_r;
   logic [7:0]    char_s;
   logic [7:0]    push_data_s;
   logic [7:0]    head_s;
   logic          armed_r;
   logic          halt_req_r;
   logic          halt_done_r;
   logic          con_wr_s;
   logic          halt_wr_s;
   logic          stat_rd_s;
   logic          empty_s;
   logic          full_s;
   logic          pop_s;
   logic          can_push_s;
   logic          push_s;
   logic          capture_s;
   logic          wrap_need_s;
   logic          uart_ready_s;
   logic          tx_busy_s;
   logic [31:0]   status_s;
   logic          unused_ok_s;

   assign con_wr_s  = (address == CON_ADDR)  && (data_we != 4'h0);
   assign halt_wr_s = (address == HALT_ADDR) && (data_we != 4'h0);
   assign stat_rd_s = (address == STAT_ADDR) && (data_we == 4'h0);
   assign char_s    = data_write[31:24];

   assign count_s = wr_ptr_r - rd_ptr_r;
   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign head_s  = fifo_mem_r[rd_ptr_r[AW-1:0]];
   assign pop_s   = !empty_s && uart_ready_s;

   // A pop in the same cycle frees the slot, so a full FIFO need not stall then
   assign can_push_s  = !full_s || pop_s;
   assign wrap_need_s = WRAP_EN && (column_r == LINE_MAX_B) && (char_s != LF);
   assign push_s      = con_wr_s && armed_r && can_push_s;
   assign capture_s   = push_s && !wrap_need_s;
   assign push_data_s = wrap_need_s ? LF : char_s;
   assign stall_sig   = con_wr_s && armed_r && (!can_push_s || wrap_need_s);
   assign halt_done   = halt_done_r;
   assign unused_ok_s = ^data_write[23:0];

   // Status word assembled from the bit positions shared with software
   always_comb begin
      status_s                         = 32'h0;
      status_s[STAT_EMPTY]             = empty_s;
      status_s[STAT_FULL]              = full_s;
      status_s[STAT_BUSY]              = tx_busy_s;
      status_s[STAT_HALT]              = halt_req_r;
      status_s[STAT_COUNT_LSB +: 8]    = 8'(count_s);
      if (stat_rd_s) begin
         data_read = status_s;
      end else begin
         data_read = 32'h0;
      end
   end

   // FIFO storage, written at the push pointer
   always_ff @(posedge clock_in) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
      end
   end

   // Pointers, line column, capture arming and end-of-run tracking
   always_ff @(posedge clock_in) begin
      if (!reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         column_r    <= 8'h00;
         armed_r     <= 1'b1;
         halt_req_r  <= 1'b0;
         halt_done_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (push_data_s == LF) begin
               column_r <= 8'h00;
            end else if (column_r != 8'hFF) begin
               column_r <= column_r + 8'd1;
            end
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         // One character per access: re-arm only after the write strobe drops
         if (capture_s) begin
            armed_r <= 1'b0;
         end else if (!con_wr_s) begin
            armed_r <= 1'b1;
         end
         if (halt_wr_s) begin
            halt_req_r <= 1'b1;
         end
         if (halt_req_r && empty_s && !tx_busy_s) begin
            halt_done_r <= 1'b1;
         end
      end
   end

   debug_uart_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_uart (
      .clock_in   (clock_in),
      .reset      (reset),
      .byte_data  (head_s),
      .byte_valid (!empty_s),
      .byte_ready (uart_ready_s),
      .tx         (tx),
      .busy       (tx_busy_s)
   );

endmodule

// File: tb/tb_debug_console_tx.sv
// Scoreboard bench for debug_console_tx: a character model fills an expected queue,
// a line monitor decodes every 8N1 frame and compares its full waveform.
module tb_debug_console_tx;
   import debug_console_pkg::*;

   logic        clock_in   = 1'b0;
   logic        reset      = 1'b0;
   logic [31:0] address    = 32'h0;
   logic [31:0] data_write = 32'h0;
   logic [3:0]  data_we    = 4'h0;
   logic [31:0] data_read;
   logic        stall_sig;
   logic        tx;
   logic        halt_done;

   int n_checks    = 0;
   int n_fail      = 0;
   int col_m       = 0;
   int sent        = 0;
   int rx_count    = 0;
   int wr_idx      = 0;
   int first_stall = 0;
   bit in_frame    = 1'b0;
   bit mon_abort   = 1'b0;
   logic [7:0]  exp_q [$];
   logic [31:0] rd_v;

   debug_console_tx #(
      .FIFO_DEPTH (16),
      .CLK_DIV    (4),
      .LINE_MAX   (4)
   ) dut (
      .clock_in   (clock_in),
      .reset      (reset),
      .address    (address),
      .data_write (data_write),
      .data_we    (data_we),
      .data_read  (data_read),
      .stall_sig  (stall_sig),
      .tx         (tx),
      .halt_done  (halt_done)
   );

   always #5 clock_in = ~clock_in;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference line model: auto break before the 5th character of a line
   task automatic model_push(input logic [7:0] c);
      if (col_m == 4 && c != 8'h0A) begin
         exp_q.push_back(8'h0A);
         sent++;
         col_m = 0;
      end
      exp_q.push_back(c);
      sent++;
      col_m = (c == 8'h0A) ? 0 : col_m + 1;
   endtask

   task automatic con_write(input logic [7:0] c);
      int b;
      model_push(c);
      wr_idx++;
      @(negedge clock_in);
      address    = CON_ADDR;
      data_we    = 4'hF;
      data_write = {c, 24'h000000};
      #1;
      b = 500;
      while (stall_sig === 1'b1 && b > 0) begin
         if (first_stall == 0) first_stall = wr_idx;
         @(negedge clock_in);
         #1;
         b--;
      end
      if (b == 0) check_eq("stall_timeout", stall_sig, 1'b0);
      @(posedge clock_in);
      @(negedge clock_in);
      address    = 32'h0;
      data_we    = 4'h0;
      data_write = 32'h0;
      @(posedge clock_in);
   endtask

   task automatic hold_write(input logic [7:0] c, input int n);
      model_push(c);
      @(negedge clock_in);
      address    = CON_ADDR;
      data_we    = 4'hF;
      data_write = {c, 24'h000000};
      repeat (n) @(posedge clock_in);
      @(negedge clock_in);
      address    = 32'h0;
      data_we    = 4'h0;
      data_write = 32'h0;
      @(posedge clock_in);
   endtask

   task automatic halt_write();
      @(negedge clock_in);
      address = HALT_ADDR;
      data_we = 4'h1;
      @(negedge clock_in);
      address = 32'h0;
      data_we = 4'h0;
   endtask

   task automatic status_read(output logic [31:0] v);
      @(negedge clock_in);
      address = STAT_ADDR;
      data_we = 4'h0;
      #1;
      v = data_read;
   endtask

   task automatic wait_drain();
      int b = 3000;
      do begin
         @(negedge clock_in);
         #2;
         b--;
      end while ((exp_q.size() != 0 || in_frame) && b > 0);
      if (exp_q.size() != 0 || in_frame)
         check_eq("drain_timeout", 64'(exp_q.size()) + 64'(in_frame), 64'h0);
      check_eq("rx_count", rx_count, sent);
   endtask

   // Line monitor: 40 samples per frame (start, 8 data LSB first, stop; 4 clocks each)
   initial begin : rx_monitor
      logic [39:0] wave;
      logic [39:0] exp_wave;
      logic [7:0]  eb;
      int          bi;
      forever begin
         @(negedge clock_in);
         if (tx === 1'b0) begin
            in_frame = 1'b1;
            wave     = 40'h0;
            for (int j = 1; j < 40; j++) begin
               @(negedge clock_in);
               wave[j] = tx;
            end
            if (!mon_abort) begin
               if (exp_q.size() > 0) begin
                  eb = exp_q.pop_front();
                  for (int j = 0; j < 40; j++) begin
                     bi = j / 4;
                     exp_wave[j] = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : eb[bi-1];
                  end
               end else begin
                  exp_wave = '1;
               end
               rx_count++;
               check_eq("frame", wave, exp_wave);
            end
            in_frame = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      repeat (3) @(negedge clock_in);
      reset = 1'b1;
      #1;
      check_eq("rst_tx", tx, 1'b1);
      check_eq("rst_stall", stall_sig, 1'b0);
      check_eq("rst_halt", halt_done, 1'b0);
      check_eq("rst_rdata", data_read, 32'h0);
      status_read(rd_v);
      check_eq("rst_status", rd_v, 32'h0000_0001);

      con_write(8'h41);
      wait_drain();

      hold_write(8'h42, 5);
      wait_drain();
      hold_write(8'h42, 5);
      wait_drain();
      con_write(8'h0A);
      wait_drain();

      con_write(8'h78);
      con_write(8'h79);
      con_write(8'h7A);
      status_read(rd_v);
      check_eq("stat_busy", rd_v, 32'h0000_0204);
      con_write(8'h0A);
      wait_drain();

      // "ABCDE" then "AB\nCDEF"; the model places the breaks
      con_write(8'h41); con_write(8'h42); con_write(8'h43); con_write(8'h44); con_write(8'h45);
      con_write(8'h41); con_write(8'h42); con_write(8'h0A);
      con_write(8'h43); con_write(8'h44); con_write(8'h45); con_write(8'h46);
      con_write(8'h0A);
      wait_drain();

      // First char leaves for the UART at once, so 16 more fill the FIFO: write 18 stalls
      first_stall = 0;
      wr_idx      = 0;
      for (int i = 0; i < 20; i++) begin
         con_write((i % 4 == 3) ? 8'h0A : 8'(8'h61 + i % 4));
      end
      check_eq("first_stall", first_stall, 18);
      wait_drain();

      con_write(8'h68);
      con_write(8'h69);
      halt_write();
      #1;
      check_eq("halt_early", halt_done, 1'b0);
      wait_drain();
      check_eq("halt_stopbit", halt_done, 1'b0);
      @(negedge clock_in);
      #2;
      check_eq("halt_stopend", halt_done, 1'b0);
      @(negedge clock_in);
      #2;
      check_eq("halt_set", halt_done, 1'b1);
      repeat (10) @(negedge clock_in);
      check_eq("halt_sticky", halt_done, 1'b1);
      status_read(rd_v);
      check_eq("stat_halt", rd_v, 32'h0000_0009);

      con_write(8'h72);
      con_write(8'h73);
      begin
         int b = 200;
         while (!in_frame && b > 0) begin
            @(negedge clock_in);
            b--;
         end
         check_eq("frame_started", in_frame, 1'b1);
      end
      repeat (6) @(negedge clock_in);
      mon_abort = 1'b1;
      reset     = 1'b0;
      @(negedge clock_in);
      reset   = 1'b1;
      address = STAT_ADDR;
      data_we = 4'h0;
      #1;
      check_eq("midrst_tx", tx, 1'b1);
      check_eq("midrst_halt", halt_done, 1'b0);
      check_eq("midrst_status", data_read, 32'h0000_0001);
      check_eq("midrst_stall", stall_sig, 1'b0);
      col_m = 0;
      repeat (50) @(negedge clock_in);
      exp_q.delete();
      mon_abort = 1'b0;
      sent      = rx_count;

      con_write(8'h5A);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
